// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and bit-timing constants for the UART byte controller.
// Shared by uart_byte_ctrl and uart_rx_core (optional macro UART_RX_HOLD_EN).
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;
    localparam int CNT_W                = 16;
    localparam int BIT_IDX_W            = 3;

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Terminal count of the bit timer (last cycle of a bit period).
    function automatic logic [CNT_W-1:0] bit_last(input int clks);
        return CNT_W'(clks - 1);
    endfunction

    // Timer value at which the middle of a bit is sampled.
    function automatic logic [CNT_W-1:0] bit_half(input int clks);
        return CNT_W'(clks / 2);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: synchronizes the serial input and deframes 8N1 bytes.
// Emits a one-cycle done pulse with the byte, or a framing-error pulse.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rxd,
    output logic                 byte_done,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 frame_err
);

    localparam logic [CNT_W-1:0] LAST = bit_last(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = bit_half(CLKS_PER_BIT);

    logic                 rxd_meta;
    logic                 rxd_sync;
    logic                 rxd_prev;
    logic                 fall;

    rx_state_t            state_q;
    rx_state_t            state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [BIT_IDX_W-1:0] bit_q;
    logic [BIT_IDX_W-1:0] bit_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 done_q;
    logic                 done_d;
    logic                 err_q;
    logic                 err_d;

    // Two-flop synchronizer, plus a delayed copy for falling-edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign fall = rxd_prev & ~rxd_sync;

    // Receiver state, bit timer, shift register and result pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: the timer starts at 1 on the detected edge so
    // that every sample lands HALF cycles into its bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = CNT_W'(1);
                if (fall) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    done_d  = rxd_sync;
                    err_d   = ~rxd_sync;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign byte_done = done_q;
    assign byte_data = shift_q;
    assign frame_err = err_q;

endmodule

// File: rtl/uart_byte_ctrl.sv
// uart_byte_ctrl: 8N1 UART transmitter plus receive arming and delivery.
// Define UART_RX_HOLD_EN to keep one byte that arrives while unarmed.
module uart_byte_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] UART_BYTE_OUT,
    input  logic                 UART_START_SEND,
    input  logic                 UART_START_RECEIVE,
    output logic [1:0]           UART_RESPONSE,
    output logic [DATA_BITS-1:0] UART_BYTE_IN,
    output logic                 UART_TXD,
    input  logic                 UART_RXD,
    output logic                 rx_frame_err
);

    localparam logic [CNT_W-1:0] LAST = bit_last(CLKS_PER_BIT);

    tx_state_t            tx_state_q;
    tx_state_t            tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q;
    logic [CNT_W-1:0]     tx_cnt_d;
    logic [BIT_IDX_W-1:0] tx_bit_q;
    logic [BIT_IDX_W-1:0] tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic [DATA_BITS-1:0] tx_shift_d;
    logic                 txd_q;
    logic                 txd_d;
    logic                 tx_done_q;
    logic                 tx_done_d;
    logic                 send_q;
    logic                 send_rise;

    logic                 rx_done;
    logic [DATA_BITS-1:0] rx_data;
    logic                 armed_q;
    logic                 armed;
    logic                 deliver;
    logic [DATA_BITS-1:0] deliver_data;
    logic                 rx_resp_q;
    logic [DATA_BITS-1:0] byte_in_q;

    assign send_rise = UART_START_SEND & ~send_q;

    // Remember the previous send request level for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            send_q <= 1'b0;
        end else begin
            send_q <= UART_START_SEND;
        end
    end

    // Transmitter state, timer, shifter and the registered line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= tx_done_d ? 1'b1 : txd_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Next-state logic: the line value is computed one cycle ahead so
    // the output flop changes exactly on each bit boundary.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_done_d  = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                txd_d    = 1'b1;
                if (send_rise) begin
                    tx_state_d = TX_START;
                    tx_shift_d = UART_BYTE_OUT;
                    txd_d      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                    txd_d      = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == LAST_BIT) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                    tx_done_d  = 1'b1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
            end
        endcase
    end

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .reset_n  (reset_n),
        .rxd      (UART_RXD),
        .byte_done(rx_done),
        .byte_data(rx_data),
        .frame_err(rx_frame_err)
    );

    assign armed = UART_START_RECEIVE | armed_q;

`ifdef UART_RX_HOLD_EN
    logic                 hold_valid_q;
    logic [DATA_BITS-1:0] hold_q;

    // A held byte has priority; a newer byte is dropped while it waits.
    always_comb begin
        deliver      = armed & (hold_valid_q | rx_done);
        deliver_data = hold_valid_q ? hold_q : rx_data;
    end

    // One-entry hold register, filled only while nobody is armed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else if (deliver) begin
            hold_valid_q <= 1'b0;
        end else if (rx_done && !hold_valid_q) begin
            hold_valid_q <= 1'b1;
            hold_q       <= rx_data;
        end
    end
`else
    // Without a hold register an unarmed byte is simply lost.
    always_comb begin
        deliver      = armed & rx_done;
        deliver_data = rx_data;
    end
`endif

    // Arming flag, delivered byte and the receive response pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_q   <= 1'b0;
            rx_resp_q <= 1'b0;
            byte_in_q <= '0;
        end else begin
            rx_resp_q <= deliver;
            if (deliver) begin
                byte_in_q <= deliver_data;
                armed_q   <= 1'b0;
            end else if (UART_START_RECEIVE) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign UART_RESPONSE = {rx_resp_q, tx_done_q};
    assign UART_BYTE_IN  = byte_in_q;
    assign UART_TXD      = txd_q;

endmodule

// File: tb/tb_uart_byte_ctrl.sv
// tb_uart_byte_ctrl: directed tests of the UART byte controller at 4 clk/bit.
// Expectations follow UART_RX_HOLD_EN when the bench is built with it.
module tb_uart_byte_ctrl;

    localparam int CPB = 4;

`ifdef UART_RX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [7:0] UART_BYTE_OUT;
    logic       UART_START_SEND;
    logic       UART_START_RECEIVE;
    logic [1:0] UART_RESPONSE;
    logic [7:0] UART_BYTE_IN;
    logic       UART_TXD;
    logic       UART_RXD;
    logic       rx_frame_err;

    int checks = 0;
    int failures = 0;
    int tx_pulses = 0;
    int rx_pulses = 0;
    int err_pulses = 0;
    logic [7:0] last_byte = 8'h00;

    uart_byte_ctrl #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .UART_BYTE_OUT     (UART_BYTE_OUT),
        .UART_START_SEND   (UART_START_SEND),
        .UART_START_RECEIVE(UART_START_RECEIVE),
        .UART_RESPONSE     (UART_RESPONSE),
        .UART_BYTE_IN      (UART_BYTE_IN),
        .UART_TXD          (UART_TXD),
        .UART_RXD          (UART_RXD),
        .rx_frame_err      (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (UART_RESPONSE[0]) tx_pulses++;
            if (UART_RESPONSE[1]) rx_pulses++;
            if (rx_frame_err) err_pulses++;
        end
    end

    // Serial stimulus: start bit, 8 data bits LSB first, given stop bit.
    task automatic drive_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            UART_RXD = f[k];
            repeat (CPB) @(negedge clk);
        end
        UART_RXD = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (UART_TXD !== 1'b1) begin
            failures++;
            $display("FAIL rst_txd got %b exp 1", UART_TXD);
        end
        checks++;
        if (UART_RESPONSE !== 2'b00) begin
            failures++;
            $display("FAIL rst_resp got %b exp 00", UART_RESPONSE);
        end
        checks++;
        if (UART_BYTE_IN !== 8'h00) begin
            failures++;
            $display("FAIL rst_byte_in got %h exp 00", UART_BYTE_IN);
        end
        checks++;
        if (rx_frame_err !== 1'b0) begin
            failures++;
            $display("FAIL rst_frame_err got %b exp 0", rx_frame_err);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (UART_TXD !== 1'b1 || UART_RESPONSE !== 2'b00) begin
            failures++;
            $display("FAIL post_rst_idle got txd=%b resp=%b exp 1/00",
                     UART_TXD, UART_RESPONSE);
        end
    endtask

    // Send one byte holding START_SEND for `hold` cycles; check every
    // line cycle and the single done pulse 40 cycles after the first low.
    task automatic test_tx_single(input logic [7:0] b, input int hold);
        logic [9:0] frm;
        frm = {1'b1, b, 1'b0};
        @(negedge clk);
        UART_BYTE_OUT = b;
        UART_START_SEND = 1'b1;
        for (int i = 0; i <= 41; i++) begin
            @(negedge clk);
            if (i == hold - 1) UART_START_SEND = 1'b0;
            if (i < 40) begin
                checks++;
                if (UART_TXD !== frm[i/4]) begin
                    failures++;
                    $display("FAIL tx_%h_bit cyc=%0d got %b exp %b",
                             b, i, UART_TXD, frm[i/4]);
                end
                checks++;
                if (UART_RESPONSE[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL tx_%h_early_resp cyc=%0d got 1 exp 0", b, i);
                end
            end else begin
                checks++;
                if (UART_RESPONSE[0] !== (i == 40)) begin
                    failures++;
                    $display("FAIL tx_%h_resp cyc=%0d got %b exp %b",
                             b, i, UART_RESPONSE[0], (i == 40));
                end
                checks++;
                if (UART_TXD !== 1'b1) begin
                    failures++;
                    $display("FAIL tx_%h_idle cyc=%0d got %b exp 1",
                             b, i, UART_TXD);
                end
            end
        end
    endtask

    // Each new byte is requested as soon as the done pulse is seen, so
    // frames follow each other at the minimum 41-cycle pitch.
    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        logic [9:0] frm;
        int pulses;
        bytes[0] = 8'h01;
        bytes[1] = 8'h02;
        bytes[2] = 8'h03;
        bytes[3] = 8'h04;
        pulses = 0;
        @(negedge clk);
        UART_BYTE_OUT = bytes[0];
        UART_START_SEND = 1'b1;
        for (int f = 0; f < 4; f++) begin
            frm = {1'b1, bytes[f], 1'b0};
            for (int i = 0; i <= 40; i++) begin
                @(negedge clk);
                if (i == 0) UART_START_SEND = 1'b0;
                if (UART_RESPONSE[0]) pulses++;
                if (i < 40) begin
                    checks++;
                    if (UART_TXD !== frm[i/4]) begin
                        failures++;
                        $display("FAIL b2b_f%0d_bit cyc=%0d got %b exp %b",
                                 f, i, UART_TXD, frm[i/4]);
                    end
                end else begin
                    checks++;
                    if (UART_RESPONSE[0] !== 1'b1) begin
                        failures++;
                        $display("FAIL b2b_f%0d_resp got 0 exp 1", f);
                    end
                    if (f < 3) begin
                        UART_BYTE_OUT = bytes[f+1];
                        UART_START_SEND = 1'b1;
                    end
                end
            end
        end
        repeat (5) begin
            @(negedge clk);
            if (UART_RESPONSE[0]) pulses++;
        end
        checks++;
        if (pulses != 4) begin
            failures++;
            $display("FAIL b2b_pulse_count got %0d exp 4", pulses);
        end
    endtask

    task automatic test_rx_receive();
        int c_rx;
        int c_err;
        bit found;
        @(negedge clk);
        #2;
        c_rx = rx_pulses;
        c_err = err_pulses;
        UART_START_RECEIVE = 1'b1;
        drive_rx(8'h3C, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 15 && !found; k++) begin
            @(negedge clk);
            if (UART_RESPONSE[1]) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rx_3c_resp got none exp pulse within 15 cycles");
        end
        checks++;
        if (UART_BYTE_IN !== 8'h3C) begin
            failures++;
            $display("FAIL rx_3c_byte got %h exp 3c", UART_BYTE_IN);
        end
        UART_START_RECEIVE = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        checks++;
        if (rx_pulses - c_rx != 1) begin
            failures++;
            $display("FAIL rx_3c_pulses got %0d exp 1", rx_pulses - c_rx);
        end
        checks++;
        if (err_pulses != c_err) begin
            failures++;
            $display("FAIL rx_3c_ferr got %0d exp 0", err_pulses - c_err);
        end
        checks++;
        if (UART_BYTE_IN !== 8'h3C) begin
            failures++;
            $display("FAIL rx_3c_hold got %h exp 3c", UART_BYTE_IN);
        end
        last_byte = 8'h3C;
    endtask

    // Two bytes arrive unarmed; only the first may survive in the hold.
    task automatic test_rx_unarmed();
        int c_rx;
        logic [7:0] exp_b;
        exp_b = HOLD ? 8'h7E : last_byte;
        @(negedge clk);
        #2;
        c_rx = rx_pulses;
        drive_rx(8'h7E, 1'b1);
        drive_rx(8'h81, 1'b1);
        repeat (15) @(negedge clk);
        #2;
        checks++;
        if (rx_pulses != c_rx) begin
            failures++;
            $display("FAIL unarmed_no_resp got %0d exp 0", rx_pulses - c_rx);
        end
        @(negedge clk);
        UART_START_RECEIVE = 1'b1;
        @(negedge clk);
        checks++;
        if (UART_RESPONSE[1] !== HOLD) begin
            failures++;
            $display("FAIL arm_resp got %b exp %b", UART_RESPONSE[1], HOLD);
        end
        checks++;
        if (UART_BYTE_IN !== exp_b) begin
            failures++;
            $display("FAIL arm_byte got %h exp %h", UART_BYTE_IN, exp_b);
        end
        UART_START_RECEIVE = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        checks++;
        if (rx_pulses - c_rx != int'(HOLD)) begin
            failures++;
            $display("FAIL arm_pulses got %0d exp %0d",
                     rx_pulses - c_rx, int'(HOLD));
        end
        last_byte = exp_b;
    endtask

    task automatic test_rx_glitch();
        int c_rx;
        int c_err;
        @(negedge clk);
        #2;
        c_rx = rx_pulses;
        c_err = err_pulses;
        UART_START_RECEIVE = 1'b1;
        UART_RXD = 1'b0;
        @(negedge clk);
        UART_RXD = 1'b1;
        repeat (50) @(negedge clk);
        #2;
        checks++;
        if (rx_pulses != c_rx) begin
            failures++;
            $display("FAIL glitch_resp got %0d exp 0", rx_pulses - c_rx);
        end
        checks++;
        if (err_pulses != c_err) begin
            failures++;
            $display("FAIL glitch_ferr got %0d exp 0", err_pulses - c_err);
        end
    endtask

    task automatic test_rx_frame_err();
        int c_rx;
        int c_err;
        @(negedge clk);
        #2;
        c_rx = rx_pulses;
        c_err = err_pulses;
        UART_START_RECEIVE = 1'b1;
        drive_rx(8'h55, 1'b0);
        repeat (15) @(negedge clk);
        #2;
        checks++;
        if (err_pulses - c_err != 1) begin
            failures++;
            $display("FAIL ferr_pulse got %0d exp 1", err_pulses - c_err);
        end
        checks++;
        if (rx_pulses != c_rx) begin
            failures++;
            $display("FAIL ferr_resp got %0d exp 0", rx_pulses - c_rx);
        end
        checks++;
        if (UART_BYTE_IN !== last_byte) begin
            failures++;
            $display("FAIL ferr_byte got %h exp %h", UART_BYTE_IN, last_byte);
        end
        UART_START_RECEIVE = 1'b0;
    endtask

    task automatic test_reset_mid_tx();
        int c_tx;
        @(negedge clk);
        #2;
        c_tx = tx_pulses;
        UART_BYTE_OUT = 8'h18;
        UART_START_SEND = 1'b1;
        @(negedge clk);
        UART_START_SEND = 1'b0;
        checks++;
        if (UART_TXD !== 1'b0) begin
            failures++;
            $display("FAIL midrst_start got %b exp 0", UART_TXD);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (UART_TXD !== 1'b0) begin
            failures++;
            $display("FAIL midrst_data got %b exp 0", UART_TXD);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (UART_TXD !== 1'b1) begin
            failures++;
            $display("FAIL midrst_txd got %b exp 1", UART_TXD);
        end
        checks++;
        if (UART_RESPONSE !== 2'b00 || UART_BYTE_IN !== 8'h00) begin
            failures++;
            $display("FAIL midrst_outs got resp=%b byte=%h exp 00/00",
                     UART_RESPONSE, UART_BYTE_IN);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(negedge clk);
        #2;
        checks++;
        if (tx_pulses != c_tx) begin
            failures++;
            $display("FAIL midrst_no_resp got %0d exp 0", tx_pulses - c_tx);
        end
        checks++;
        if (UART_TXD !== 1'b1) begin
            failures++;
            $display("FAIL midrst_idle got %b exp 1", UART_TXD);
        end
        test_tx_single(8'h5A, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        UART_BYTE_OUT = 8'h00;
        UART_START_SEND = 1'b0;
        UART_START_RECEIVE = 1'b0;
        UART_RXD = 1'b1;
        test_reset();
        test_tx_single(8'hA5, 3);
        test_back_to_back();
        test_rx_receive();
        test_rx_unarmed();
        test_rx_glitch();
        test_rx_frame_err();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
